// File: rtl/rv_wb_pkg.sv
// Shared encodings for the writeback stage: result sources, load funct3 codes
// and the writeback FSM state type.
package rv_wb_pkg;

    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_WAIT_LD = 1'b1
    } wb_state_e;

    // Widen a byte or halfword to 32 bits, replicating the top bit when signed.
    function automatic logic [31:0] extend_field(input logic [15:0] field,
                                                 input logic        is_half,
                                                 input logic        is_signed);
        logic fill;
        if (is_half) begin
            fill = is_signed & field[15];
            return {{16{fill}}, field};
        end
        fill = is_signed & field[7];
        return {{24{fill}}, field[7:0]};
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a raw memory word and sign- or
// zero-extends it according to the load funct3.
module load_extend
    import rv_wb_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // Halfword alignment uses off[1] only; off[0] faults are caught upstream.
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = extend_field({8'd0, byte_sel}, 1'b0, 1'b1);
            F3_LBU:  data_o = extend_field({8'd0, byte_sel}, 1'b0, 1'b0);
            F3_LH:   data_o = extend_field(half_sel, 1'b1, 1'b1);
            F3_LHU:  data_o = extend_field(half_sel, 1'b1, 1'b0);
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: retires MEM-stage results, waits for late load data and
// drives the registered register-file write triple (also the WB forward source).
module regfile_writeback
    import rv_wb_pkg::*;
#(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 5,
    parameter int MP_LD_TIMEOUT = 15
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     imem_valid,
    input  logic                     iflush,
    input  logic                     imem_regwrite,
    input  logic [MP_ADDR_WIDTH-1:0] imem_rd,
    input  logic [1:0]               imem_resultsrc,
    input  logic [2:0]               imem_funct3,
    input  logic [MP_DATA_WIDTH-1:0] imem_alu_result,
    input  logic [MP_DATA_WIDTH-1:0] imem_pcplus4,
    input  logic                     ild_valid,
    input  logic [MP_DATA_WIDTH-1:0] ild_data,
    output logic                     oready,
    output logic                     owen3,
    output logic [MP_ADDR_WIDTH-1:0] oa3,
    output logic [MP_DATA_WIDTH-1:0] owdata3,
    output logic                     oerr_ldto,
    output logic                     odbg_state
);

    // Handshake: an instruction transfers when imem_valid & oready & ~iflush at
    // a rising edge; oready depends on state only, never on the inputs.
    // ild_valid is a one-sided valid, looked at only while waiting for a load.

    localparam logic [7:0] TO_LAST = 8'(MP_LD_TIMEOUT - 1);

    wb_state_e                state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [MP_ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
    logic                     ld_regwrite_q, ld_regwrite_d;
    logic [2:0]               ld_funct3_q, ld_funct3_d;
    logic [1:0]               ld_off_q, ld_off_d;
    logic                     wen_q, wen_d;
    logic [MP_ADDR_WIDTH-1:0] a3_q, a3_d;
    logic [MP_DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                     accept;
    logic                     ldto_hit;
    logic [MP_DATA_WIDTH-1:0] ld_ext;

    assign oready = (state_q == S_IDLE);
    assign accept = imem_valid & oready & ~iflush;

    load_extend u_load_extend (
        .funct3_i (ld_funct3_q),
        .off_i    (ld_off_q),
        .word_i   (ild_data),
        .data_o   (ld_ext)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ld_rd_d       = ld_rd_q;
        ld_regwrite_d = ld_regwrite_q;
        ld_funct3_d   = ld_funct3_q;
        ld_off_d      = ld_off_q;
        wen_d         = 1'b0;
        a3_d          = a3_q;
        wdata_d       = wdata_q;
        ldto_hit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (imem_resultsrc == RS_LOAD) begin
                        ld_rd_d       = imem_rd;
                        ld_regwrite_d = imem_regwrite;
                        ld_funct3_d   = imem_funct3;
                        ld_off_d      = imem_alu_result[1:0];
                        cnt_d         = 8'd0;
                        state_d       = S_WAIT_LD;
                    end else if (imem_regwrite && (imem_rd != '0)) begin
                        // Reserved source 11 falls through to the ALU result.
                        wen_d   = 1'b1;
                        a3_d    = imem_rd;
                        wdata_d = (imem_resultsrc == RS_PC4) ? imem_pcplus4
                                                             : imem_alu_result;
                    end
                end
            end

            S_WAIT_LD: begin
                if (ild_valid) begin
                    state_d = S_IDLE;
                    if (ld_regwrite_q && (ld_rd_q != '0)) begin
                        wen_d   = 1'b1;
                        a3_d    = ld_rd_q;
                        wdata_d = ld_ext;
                    end
                end else if (cnt_q == TO_LAST) begin
                    ldto_hit = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            ld_rd_q       <= '0;
            ld_regwrite_q <= 1'b0;
            ld_funct3_q   <= 3'd0;
            ld_off_q      <= 2'd0;
            wen_q         <= 1'b0;
            a3_q          <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ld_rd_q       <= ld_rd_d;
            ld_regwrite_q <= ld_regwrite_d;
            ld_funct3_q   <= ld_funct3_d;
            ld_off_q      <= ld_off_d;
            wen_q         <= wen_d;
            a3_q          <= a3_d;
            wdata_q       <= wdata_d;
        end
    end

    assign owen3      = wen_q;
    assign oa3        = a3_q;
    assign owdata3    = wdata_q;
    assign oerr_ldto  = ldto_hit;
    assign odbg_state = state_q;

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writeback stage that owns the write port of the integer register file.
- Captures retiring instructions from the memory stage, waits for late load data with a handshake, and aligns and sign/zero-extends loads.
- Selects the result source, then drives the registered write triple (enable, address, data) into the register file.
- The same triple is exported as the WB forwarding source for the hazard unit.

Parameters:
- MP_DATA_WIDTH, 32, data width; load extension logic is defined for 32 only.
- MP_ADDR_WIDTH, 5, register address width.
- MP_LD_TIMEOUT, 15, maximum cycles spent in S_WAIT_LD before abort; range 1..255.

Ports:
- iclk  input  1  clock.
- irst_n  input  1  reset; asynchronous, active-low.
- imem_valid  input  1  MEM-stage instruction presented.
- iflush  input  1  squash the instruction presented this cycle.
- imem_regwrite  input  1  instruction writes rd.
- imem_rd  input  MP_ADDR_WIDTH  destination register.
- imem_resultsrc  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- imem_funct3  input  3  load size/sign.
- imem_alu_result  input  MP_DATA_WIDTH  ALU result, or load address.
- imem_pcplus4  input  MP_DATA_WIDTH  PC+4.
- ild_valid  input  1  load data valid.
- ild_data  input  MP_DATA_WIDTH  raw aligned word from data memory.
- oready  output  1  stage can accept (combinational from state).
- owen3  output  1  register-file write enable.
- oa3  output  MP_ADDR_WIDTH  register-file write address.
- owdata3  output  MP_DATA_WIDTH  register-file write data.
- oerr_ldto  output  1  one-cycle load-timeout pulse.

Behaviour:
- Reset: async on irst_n low. State goes to S_IDLE, the timeout counter clears, and all outputs are 0 except oready=1.
- Accept condition: imem_valid & oready & ~iflush. iflush discards only the presented instruction; it never aborts an in-progress load wait.
- S_IDLE, accepted with resultsrc != 01:
  - At the next edge, register owen3 = imem_regwrite & (imem_rd != 0).
  - oa3 = imem_rd.
  - owdata3 = PC+4 if resultsrc = 10, else the ALU result.
  - Latency is 1 cycle from accept to write-enable visible; the register file commits at the following edge.
- S_IDLE, accepted with resultsrc = 01:
  - Latch rd, regwrite, funct3 and alu_result[1:0]; go to S_WAIT_LD; clear the counter.
  - owen3 = 0 during the next cycle.
- S_WAIT_LD:
  - oready = 0 (upstream stalls). ild_valid is sampled only in this state.
  - On ild_valid: register the extended data, owen3 = latched regwrite & (rd != 0), return to S_IDLE. oready is 1 again in the cycle owen3 is high, so back-to-back accept is allowed.
  - Otherwise the counter increments. When the counter reaches MP_LD_TIMEOUT-1 without ild_valid: pulse oerr_ldto for 1 cycle, perform no write, return to S_IDLE.
- Write enable: owen3 is high exactly 1 cycle per retired write and is 0 in every other cycle. oa3 and owdata3 hold their last values when owen3 = 0.
- Load extension, using off = latched addr[1:0]:
  - 000 LB: sign-extend byte[off].
  - 100 LBU: zero-extend byte[off].
  - 001 LH: sign-extend halfword[off[1]].
  - 101 LHU: zero-extend halfword[off[1]].
  - 010 LW and all other codes: full word.
  - off[0] is ignored for halfwords; misaligned access is trapped upstream, not here.
- rd = 0 never produces owen3, even with regwrite = 1.

Decomposition:
- Package rv_wb_pkg holds:
  - result-source encodings RS_ALU, RS_LOAD, RS_PC4;
  - load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - the state typedef S_IDLE / S_WAIT_LD.
- One combinational sub-module, load_extend (inputs funct3, off, raw word; output extended word), is reused by the forwarding path.

Test Plan:
- ALU write: accept rd=5, ALU result 0xDEADBEEF, regwrite=1 -> next cycle owen3=1, oa3=5, owdata3=0xDEADBEEF; the register file then reads x5=0xDEADBEEF.
- LB sign: load with addr[1:0]=2, funct3=000, ild_valid after 3 cycles with 0x12F0_5678 -> oready low for 3 cycles, then owen3=1, owdata3=0xFFFFFFF0; the same pattern with LBU gives 0x000000F0.
- rd=0 and flush: ALU op with rd=0, regwrite=1 -> owen3 stays 0. Any op with iflush=1 -> no state change, no write.
- Timeout: load with ild_valid never asserted -> oerr_ldto pulses exactly once in the 15th cycle of S_WAIT_LD, no write, oready=1 the next cycle.
- Reset mid-wait: drop irst_n while in S_WAIT_LD, then assert ild_valid after release -> no write, state S_IDLE, all outputs 0 except oready=1.
- Back-to-back: PC+4 op (PC+4 = 0x104, rd=1), then load LHU off=2 data 0x8001_0000 (rd=2), then ALU op (rd=3, result 7) -> writes in order: x1=0x104, x2=0x00008001, x3=7, each with a single-cycle owen3.
